// File: rtl/mul_seq_unit_pkg.sv
// Shared constants and state encoding for the iterative multiplier.
// The CPU decode package also pulls its operand/product widths from here.
package mul_seq_unit_pkg;

    localparam int MUL_WIDTH  = 24;
    localparam int MUL_PROD_W = 2 * MUL_WIDTH;
    localparam int MUL_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SIGN  = 2'd2,
        ST_WRITE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/mul_abs_neg.sv
// Conditional two's-complement: passes the operand through, or negates it.
// Serves both as |x| for signed operands and as the final product sign fix.
module mul_abs_neg #(
    parameter int W = 24
) (
    input  logic [W-1:0] operand_s,
    input  logic         negate_s,
    output logic [W-1:0] result_s
);

    // Select the operand or its two's complement
    always_comb begin
        if (negate_s) begin
            result_s = (~operand_s) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            result_s = operand_s;
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier feeding the 48-bit multiply-result register.
// Operands are latched on Start in IDLE; the product is written with a
// one-cycle MulWrite strobe after WIDTH iterations plus a sign-fix cycle.
module mul_seq_unit
    import mul_seq_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     OperandA,
    input  logic [WIDTH-1:0]     OperandB,
    output logic [2*WIDTH-1:0]   WriteData,
    output logic                 MulWrite,
    output logic                 Busy
);

    localparam int PW = 2 * WIDTH;

    mul_state_e         state_r;
    mul_state_e         state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [PW-1:0]      acc_r;
    logic [PW-1:0]      acc_next_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mcand_next_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   mplier_next_s;
    logic               neg_r;
    logic               neg_next_s;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [PW-1:0]      acc_fixed_s;
    logic [WIDTH:0]     add_sum_s;

    logic [PW-1:0]      write_data_r;
    logic               mul_write_r;
    logic               busy_r;

    assign neg_a_s = Signed & OperandA[WIDTH-1];
    assign neg_b_s = Signed & OperandB[WIDTH-1];

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
    mul_abs_neg #(.W(WIDTH)) u_abs_a (
        .operand_s (OperandA),
        .negate_s  (neg_a_s),
        .result_s  (mag_a_s)
    );

    mul_abs_neg #(.W(WIDTH)) u_abs_b (
        .operand_s (OperandB),
        .negate_s  (neg_b_s),
        .result_s  (mag_b_s)
    );

    // Final sign correction of the unsigned product
    mul_abs_neg #(.W(PW)) u_sign_fix (
        .operand_s (acc_r),
        .negate_s  (neg_r),
        .result_s  (acc_fixed_s)
    );

    // One shift-add step: WIDTH+1-bit add so the carry is shifted in, never lost
    always_comb begin
        if (mplier_r[0]) begin
            add_sum_s = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            add_sum_s = {1'b0, acc_r[PW-1:WIDTH]};
        end
    end

    // Next-state and datapath update for IDLE -> RUN -> SIGN -> WRITE
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        acc_next_s    = acc_r;
        mcand_next_s  = mcand_r;
        mplier_next_s = mplier_r;
        neg_next_s    = neg_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    mcand_next_s  = mag_a_s;
                    mplier_next_s = mag_b_s;
                    neg_next_s    = Signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                    acc_next_s    = {PW{1'b0}};
                    cnt_next_s    = {CNT_W{1'b0}};
                    state_next_s  = ST_RUN;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_next_s    = {add_sum_s, acc_r[WIDTH-1:1]};
                mplier_next_s = {1'b0, mplier_r[WIDTH-1:1]};
                cnt_next_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_next_s = ST_SIGN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SIGN: begin
                acc_next_s   = acc_fixed_s;
                state_next_s = ST_WRITE;
            end
            ST_WRITE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_next_s;
            mplier_r <= mplier_next_s;
            neg_r    <= neg_next_s;
        end
    end

    // Registered outputs, timed to coincide with the state they describe
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            write_data_r <= {PW{1'b0}};
            mul_write_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (state_next_s == ST_WRITE) begin
                write_data_r <= acc_next_s;
            end else begin
                write_data_r <= write_data_r;
            end
            mul_write_r <= (state_next_s == ST_WRITE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign WriteData = write_data_r;
    assign MulWrite  = mul_write_r;
    assign Busy      = busy_r;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Scoreboard bench for mul_seq_unit: stimulus pushes expected products with
// their due cycle; a monitor pops and compares on every MulWrite.
module tb_mul_seq_unit;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [23:0] OperandA;
    logic [23:0] OperandB;
    logic [47:0] WriteData;
    logic        MulWrite;
    logic        Busy;

    typedef struct packed {
        logic [47:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   failures;

    mul_seq_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Signed    (Signed),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .WriteData (WriteData),
        .MulWrite  (MulWrite),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: every MulWrite cycle must match the oldest expected entry
    always @(negedge Clock) begin : monitor
        exp_t e;
        if (MulWrite) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mulwrite cycle=%0d data=%h", cyc, WriteData);
            end else begin
                e = sb.pop_front();
                checks++;
                if (WriteData !== e.val) begin
                    failures++;
                    $display("FAIL product got=%h exp=%h", WriteData, e.val);
                end
                checks++;
                if (cyc != e.due) begin
                    failures++;
                    $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, e.due);
                end
            end
        end
    end

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check48(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the following negedge
    task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic sgn,
                         input logic [47:0] exp, input bit expect_out);
        exp_t t;
        OperandA = a;
        OperandB = b;
        Signed   = sgn;
        Start    = 1'b1;
        if (expect_out) begin
            t.val = exp;
            t.due = cyc + 26;
            sb.push_back(t);
        end
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Wait (bounded) for all expected writes, then one more cycle to return to IDLE
    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(negedge Clock);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
        @(negedge Clock);
        @(negedge Clock);
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic sgn,
                          input logic [47:0] exp);
        issue(a, b, sgn, exp, 1'b1);
        drain();
    endtask

    initial begin : stim
        int k;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        Signed   = 1'b0;
        OperandA = 24'h000000;
        OperandB = 24'h000000;
        repeat (2) @(negedge Clock);
        check48("reset_writedata", WriteData, 48'h000000000000);
        check1("reset_mulwrite", MulWrite, 1'b0);
        check1("reset_busy", Busy, 1'b0);
        Reset = 1'b0;
        @(negedge Clock);

        // Unsigned 3*5 with cycle-by-cycle Busy window
        check1("busy_before_start", Busy, 1'b0);
        issue(24'd3, 24'd5, 1'b0, 48'h00000000000F, 1'b1);
        for (int i = 1; i <= 28; i++) begin
            check1($sformatf("busy_window_%0d", i), Busy, (i <= 26));
            @(negedge Clock);
        end
        drain();

        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001);
        run_op(24'hFFFFFE, 24'h000003, 1'b1, 48'hFFFFFFFFFFFA);
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'h000000000001);
        run_op(24'h800000, 24'h800000, 1'b1, 48'h400000000000);
        run_op(24'h800000, 24'h000001, 1'b1, 48'hFFFFFF800000);
        run_op(24'h000007, 24'hFFFFFB, 1'b1, 48'hFFFFFFFFFFDD);
        run_op(24'h123456, 24'h000010, 1'b0, 48'h000001234560);
        run_op(24'h000000, 24'hFFFFFF, 1'b0, 48'h000000000000);
        run_op(24'h800000, 24'h000001, 1'b0, 48'h000000800000);

        // Start pulsed mid-operation with new operands must be ignored
        k = cyc;
        issue(24'd100, 24'd200, 1'b0, 48'h000000004E20, 1'b1);
        while (cyc < k + 10) @(negedge Clock);
        check1("busy_mid_op", Busy, 1'b1);
        OperandA = 24'd7;
        OperandB = 24'd7;
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        drain();

        // Start held high: second operation begins the cycle after WRITE
        k = cyc;
        begin
            exp_t t;
            t.val = 48'h00000000001E;
            t.due = k + 26;
            sb.push_back(t);
            t.due = k + 53;
            sb.push_back(t);
        end
        OperandA = 24'd5;
        OperandB = 24'd6;
        Signed   = 1'b0;
        Start    = 1'b1;
        while (cyc < k + 28) @(negedge Clock);
        Start = 1'b0;
        drain();

        // Reset mid-operation aborts with no write
        k = cyc;
        issue(24'd2, 24'd3, 1'b0, 48'h0, 1'b0);
        while (cyc < k + 12) @(negedge Clock);
        check1("busy_before_abort", Busy, 1'b1);
        check48("writedata_before_abort", WriteData, 48'h00000000001E);
        Reset = 1'b1;
        #1;
        check1("abort_busy", Busy, 1'b0);
        check48("abort_writedata", WriteData, 48'h000000000000);
        check1("abort_mulwrite", MulWrite, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (40) @(negedge Clock);
        check1("idle_after_abort", Busy, 1'b0);
        run_op(24'd2, 24'd2, 1'b0, 48'h000000000004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
